// File: rtl/vliw_bundle_packer_if.sv
// Issue-side handshake between the scalar stream, the packer and the bundle consumer.
interface vliw_bundle_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r_instr;
  logic [31:0] out_s_instr;
  logic        out_r_vld;
  logic        out_s_vld;
  logic        out_illegal;

  // Environment side: supplies instructions and consumes bundles.
  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_r_instr, out_s_instr, out_r_vld, out_s_vld, out_illegal
  );

  // Packer side.
  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_r_instr, out_s_instr, out_r_vld, out_s_vld, out_illegal
  );
endinterface

// File: rtl/vliw_bundle_packer.sv
// Packs an in-order scalar stream into {R, S} VLIW bundles, holding at most one
// unpaired instruction and emitting through a registered valid/ready output.
module vliw_bundle_packer #(
  parameter int unsigned TIMEOUT  = 8,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 rst_n,
  vliw_bundle_packer_if.slave pk
);

  typedef enum logic [2:0] {C_R, C_LD, C_ST, C_BR, C_JMP, C_ILL} cls_e;
  typedef enum logic [1:0] {EMPTY, HOLD_R, HOLD_S} state_e;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  function automatic cls_e classify(input logic [4:0] op);
    case (op)
      5'b00011, 5'b01000: classify = C_R;
      5'b01010:           classify = C_LD;
      5'b01011:           classify = C_ST;
      5'b11010:           classify = C_BR;
      5'b11100:           classify = C_JMP;
      default:            classify = C_ILL;
    endcase
  endfunction

  function automatic logic writes_rd(input cls_e c);
    return (c == C_R) || (c == C_LD);
  endfunction

  function automatic logic reads_rs1(input cls_e c);
    return (c == C_R) || (c == C_LD) || (c == C_ST) || (c == C_BR);
  endfunction

  function automatic logic reads_rs2(input cls_e c);
    return (c == C_R) || (c == C_ST) || (c == C_BR);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [7:0]  timer_q, timer_d;

  logic        out_valid_q, out_r_vld_q, out_s_vld_q, out_illegal_q;
  logic [31:0] out_r_q, out_s_q;

  logic        emit, e_rv, e_sv, e_ill;
  logic [31:0] e_r, e_s;
  logic        pair, emit_h, emit_n, take_n;

  cls_e        n_cls, h_cls;
  logic [4:0]  h_rd;
  logic        holding, ofree, accept, n_is_s, n_ctrl, conflict, pair_ok, stall_n, in_ready;

  // Classify the incoming word and decide whether it may share a bundle with the held one
  always_comb begin
    n_cls    = classify(pk.in_instr[31:27]);
    h_cls    = classify(hold_q[31:27]);
    h_rd     = hold_q[26:22];
    holding  = (state_q != EMPTY);
    ofree    = !out_valid_q || pk.out_ready;
    n_is_s   = n_cls inside {C_LD, C_ST, C_BR, C_JMP};
    n_ctrl   = n_cls inside {C_BR, C_JMP};
    conflict = writes_rd(h_cls) &&
               ((reads_rs1(n_cls) && (pk.in_instr[21:17] == h_rd)) ||
                (reads_rs2(n_cls) && (pk.in_instr[16:12] == h_rd)) ||
                (writes_rd(n_cls) && (pk.in_instr[26:22] == h_rd)));
    pair_ok  = !conflict && (((state_q == HOLD_R) && n_is_s) ||
                             ((state_q == HOLD_S) && (n_cls == C_R)));
    stall_n  = (n_cls == C_ILL) || (n_ctrl && !pair_ok);
    in_ready = ofree && !(holding && (pk.flush || (pk.in_valid && stall_n)));
    accept   = pk.in_valid && in_ready;
  end

  // State register: current hold state, staged word and wait timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      hold_q  <= NOP_WORD;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
    end
  end

  // Next state and the bundle to load into the output register
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    timer_d = timer_q;
    pair    = 1'b0;
    emit_h  = 1'b0;
    emit_n  = 1'b0;
    take_n  = 1'b0;
    e_r     = NOP_WORD;
    e_s     = NOP_WORD;
    e_rv    = 1'b0;
    e_sv    = 1'b0;
    e_ill   = 1'b0;
    if (holding && (timer_q != TMAX)) timer_d = timer_q + 8'd1;
    // A stalled control/illegal word can only be accepted while holding if it
    // pairs, so emit_h and emit_n never fire together.
    if (ofree) begin
      if (accept) begin
        if (holding && pair_ok) begin
          pair = 1'b1;
        end else begin
          emit_h = holding;
          if ((n_cls == C_ILL) || n_ctrl || pk.flush) emit_n = 1'b1;
          else                                        take_n = 1'b1;
        end
      end else begin
        emit_h = holding && (pk.flush || pk.in_valid || (timer_q == TMAX));
      end
    end
    emit = pair || emit_h || emit_n;
    if (pair) begin
      e_rv = 1'b1;
      e_sv = 1'b1;
      e_r  = (state_q == HOLD_R) ? hold_q : pk.in_instr;
      e_s  = (state_q == HOLD_R) ? pk.in_instr : hold_q;
    end else if (emit_h) begin
      if (state_q == HOLD_R) begin e_r = hold_q; e_rv = 1'b1; end
      else                   begin e_s = hold_q; e_sv = 1'b1; end
    end else if (emit_n) begin
      if (n_cls == C_ILL)    begin e_r = pk.in_instr; e_ill = 1'b1; end
      else if (n_cls == C_R) begin e_r = pk.in_instr; e_rv  = 1'b1; end
      else                   begin e_s = pk.in_instr; e_sv  = 1'b1; end
    end
    if (take_n) begin
      state_d = (n_cls == C_R) ? HOLD_R : HOLD_S;
      hold_d  = pk.in_instr;
      timer_d = '0;
    end else if (pair || emit_h) begin
      state_d = EMPTY;
      timer_d = '0;
    end
  end

  // Output register: loads only when the slot is free, otherwise holds its bundle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_r_q       <= NOP_WORD;
      out_s_q       <= NOP_WORD;
      out_r_vld_q   <= 1'b0;
      out_s_vld_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else if (ofree) begin
      out_valid_q <= emit;
      if (emit) begin
        out_r_q       <= e_r;
        out_s_q       <= e_s;
        out_r_vld_q   <= e_rv;
        out_s_vld_q   <= e_sv;
        out_illegal_q <= e_ill;
      end
    end
  end

  // Drive the interface outputs
  always_comb begin
    pk.in_ready    = in_ready;
    pk.out_valid   = out_valid_q;
    pk.out_r_instr = out_r_q;
    pk.out_s_instr = out_s_q;
    pk.out_r_vld   = out_r_vld_q;
    pk.out_s_vld   = out_s_vld_q;
    pk.out_illegal = out_illegal_q;
  end

endmodule

// File: tb/tb_vliw_bundle_packer.sv
// Self-checking bench for vliw_bundle_packer: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_vliw_bundle_packer;

  localparam int TO = 8;

  localparam logic [31:0] ADD  = 32'h1844_3000; // add r1,r2,r3
  localparam logic [31:0] ADD5 = 32'h1944_3000; // add r5,r2,r3
  localparam logic [31:0] LD6  = 32'h514C_0000; // load r5,[r6]
  localparam logic [31:0] LD1  = 32'h5142_0000; // load r5,[r1]
  localparam logic [31:0] JMP  = 32'hE000_0000; // jump
  localparam logic [31:0] ILL  = 32'hF800_0000; // unrecognised opcode

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vliw_bundle_packer_if bus ();

  vliw_bundle_packer #(.TIMEOUT(TO), .NOP_WORD(32'h0000_0000)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pk   (bus)
  );

  int n_checks;
  int n_errors;

  typedef struct {
    bit v;
    logic [31:0] r, s;
    bit rv, sv, ill;
  } bundle_t;

  typedef struct {
    bit          iv;
    logic [31:0] ins;
    bit          fl;
    bit          ordy;
    bit          x_rdy;
    bit          x_ov;
    logic [31:0] x_r, x_s;
    bit          x_rv, x_sv, x_ill;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state: optional held word, its wait count, and the output bundle.
  bit          m_held;
  logic [31:0] m_h;
  int          m_wait;
  bundle_t     m_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // 0=R 1=load 2=store 3=branch 4=jump 5=illegal
  function automatic int kind(input logic [31:0] w);
    case (w[31:27])
      5'b00011, 5'b01000: return 0;
      5'b01010:           return 1;
      5'b01011:           return 2;
      5'b11010:           return 3;
      5'b11100:           return 4;
      default:            return 5;
    endcase
  endfunction

  function automatic bit hazard(input logic [31:0] h, input logic [31:0] n);
    int  nk;
    bit  r1, r2, nw;
    nk = kind(n);
    if (kind(h) > 1) return 1'b0;
    r1 = (nk <= 3);
    r2 = (nk == 0) || (nk == 2) || (nk == 3);
    nw = (nk <= 1);
    return (r1 && n[21:17] == h[26:22]) || (r2 && n[16:12] == h[26:22]) ||
           (nw && n[26:22] == h[26:22]);
  endfunction

  function automatic bit can_pair(input logic [31:0] h, input logic [31:0] n);
    if (kind(n) == 5) return 1'b0;
    if ((kind(h) == 0) == (kind(n) == 0)) return 1'b0;
    return !hazard(h, n);
  endfunction

  function automatic bit m_inrdy(input bit iv, input logic [31:0] n, input bit fl, input bit ordy);
    if (m_out.v && !ordy) return 1'b0;
    if (!m_held) return 1'b1;
    if (fl) return 1'b0;
    if (!iv) return 1'b1;
    if (kind(n) == 5) return 1'b0;
    if (kind(n) >= 3 && !can_pair(m_h, n)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bundle_t alone(input logic [31:0] w);
    bundle_t b;
    b = '{v: 1'b1, r: '0, s: '0, rv: 1'b0, sv: 1'b0, ill: 1'b0};
    if (kind(w) == 5)      begin b.r = w; b.ill = 1'b1; end
    else if (kind(w) == 0) begin b.r = w; b.rv  = 1'b1; end
    else                   begin b.s = w; b.sv  = 1'b1; end
    return b;
  endfunction

  function automatic bundle_t two(input logic [31:0] rw, input logic [31:0] sw);
    return '{v: 1'b1, r: rw, s: sw, rv: 1'b1, sv: 1'b1, ill: 1'b0};
  endfunction

  task automatic model_reset();
    m_held = 1'b0;
    m_h    = '0;
    m_wait = 0;
    m_out  = '{v: 1'b0, r: '0, s: '0, rv: 1'b0, sv: 1'b0, ill: 1'b0};
  endtask

  task automatic model_step(input bit iv, input logic [31:0] n, input bit fl, input bit ordy);
    bit      ofree, acc;
    bundle_t b;
    ofree = !m_out.v || ordy;
    acc   = iv && m_inrdy(iv, n, fl, ordy);
    b.v   = 1'b0;
    if (!ofree) begin
      if (m_held && m_wait < TO - 1) m_wait++;
    end else begin
      if (m_held && fl) begin
        b = alone(m_h); m_held = 1'b0;
      end else if (acc && !m_held) begin
        if (kind(n) >= 3 || fl) b = alone(n);
        else begin m_held = 1'b1; m_h = n; m_wait = 0; end
      end else if (acc) begin
        if (can_pair(m_h, n)) begin
          b = (kind(m_h) == 0) ? two(m_h, n) : two(n, m_h);
          m_held = 1'b0;
        end else begin
          b = alone(m_h); m_h = n; m_wait = 0;
        end
      end else if (m_held && (iv || m_wait == TO - 1)) begin
        b = alone(m_h); m_held = 1'b0;
      end else if (m_held) begin
        m_wait++;
      end
      if (b.v) m_out = b;
      else     m_out.v = 1'b0;
    end
  endtask

  task automatic check_model();
    check("model_out_valid", bus.out_valid, m_out.v);
    if (m_out.v) begin
      check("model_r_instr", bus.out_r_instr, m_out.r);
      check("model_s_instr", bus.out_s_instr, m_out.s);
      check("model_slot_vld", {bus.out_r_vld, bus.out_s_vld, bus.out_illegal},
            {m_out.rv, m_out.sv, m_out.ill});
    end
  endtask

  // One clock: drive at the negedge, check in_ready, step across the posedge, check outputs.
  task automatic cycle(input bit iv, input logic [31:0] ins, input bit fl, input bit ordy,
                       output bit rdy);
    bus.in_valid  = iv;
    bus.in_instr  = ins;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
    rdy = bus.in_ready;
    check("model_in_ready", rdy, m_inrdy(iv, ins, fl, ordy));
    @(posedge clk);
    model_step(iv, ins, fl, ordy);
    @(negedge clk);
    check_model();
  endtask

  task automatic add(input bit iv, input logic [31:0] ins, input bit fl, input bit x_rdy,
                     input bit x_ov, input logic [31:0] x_r, input logic [31:0] x_s,
                     input bit x_rv, input bit x_sv, input bit x_ill);
    tbl.push_back('{iv: iv, ins: ins, fl: fl, ordy: 1'b1, x_rdy: x_rdy, x_ov: x_ov,
                    x_r: x_r, x_s: x_s, x_rv: x_rv, x_sv: x_sv, x_ill: x_ill});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_r_instr"}, bus.out_r_instr, 0);
    check({tag, "_s_instr"}, bus.out_s_instr, 0);
    check({tag, "_vld_ill"}, {bus.out_r_vld, bus.out_s_vld, bus.out_illegal}, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] op;
    case ($urandom_range(0, 13))
      0, 1:    op = 5'b00011;
      2, 3:    op = 5'b01000;
      4, 5:    op = 5'b01010;
      6, 7:    op = 5'b01011;
      8, 9:    op = 5'b11010;
      10, 11:  op = 5'b11100;
      default: op = 5'($urandom_range(0, 31));
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 12'($urandom)};
  endfunction

  initial begin
    bit   rdy;
    int   seen;
    int   idle_left;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Pairing
    add(1, ADD,  0, 1, 0, 0,   0,   0, 0, 0);
    add(1, LD6,  0, 1, 1, ADD, LD6, 1, 1, 0);
    // RAW split, then the held load leaves after TIMEOUT idle cycles
    add(1, ADD,  0, 1, 0, 0,   0,   0, 0, 0);
    add(1, LD1,  0, 1, 1, ADD, 0,   1, 0, 0);
    for (int i = 0; i < TO - 1; i++) add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0,    0, 1, 1, 0,   LD1, 0, 1, 0);
    // Control after a held S: stall one cycle, then the jump goes alone
    add(1, LD6,  0, 1, 0, 0,   0,   0, 0, 0);
    add(1, JMP,  0, 0, 1, 0,   LD6, 0, 1, 0);
    add(1, JMP,  0, 1, 1, 0,   JMP, 0, 1, 0);
    // Illegal from EMPTY, then normal packing resumes
    add(1, ILL,  0, 1, 1, ILL, 0,   0, 0, 1);
    add(1, ADD,  0, 1, 0, 0,   0,   0, 0, 0);
    add(1, LD6,  0, 1, 1, ADD, LD6, 1, 1, 0);
    // Flush while holding, and flush from EMPTY
    add(1, ADD,  0, 1, 0, 0,   0,   0, 0, 0);
    add(0, 0,    1, 0, 1, ADD, 0,   1, 0, 0);
    add(1, LD6,  1, 1, 1, 0,   LD6, 0, 1, 0);
    // WAW blocks pairing
    add(1, LD6,  0, 1, 0, 0,   0,   0, 0, 0);
    add(1, ADD5, 0, 1, 1, 0,   LD6, 0, 1, 0);
    add(0, 0,    1, 0, 1, ADD5, 0,  1, 0, 0);
    // Held S pairs with a later R; held R pairs with a jump
    add(1, LD6,  0, 1, 0, 0,   0,   0, 0, 0);
    add(1, ADD,  0, 1, 1, ADD, LD6, 1, 1, 0);
    add(1, ADD,  0, 1, 0, 0,   0,   0, 0, 0);
    add(1, JMP,  0, 1, 1, ADD, JMP, 1, 1, 0);
    add(0, 0,    0, 1, 0, 0,   0,   0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].iv, tbl[i].ins, tbl[i].fl, tbl[i].ordy, rdy);
      check($sformatf("tbl%0d_in_ready", i), rdy, tbl[i].x_rdy);
      check($sformatf("tbl%0d_out_valid", i), bus.out_valid, tbl[i].x_ov);
      if (tbl[i].x_ov) begin
        check($sformatf("tbl%0d_r_instr", i), bus.out_r_instr, tbl[i].x_r);
        check($sformatf("tbl%0d_s_instr", i), bus.out_s_instr, tbl[i].x_s);
        check($sformatf("tbl%0d_vld_ill", i), {bus.out_r_vld, bus.out_s_vld, bus.out_illegal},
              {tbl[i].x_rv, tbl[i].x_sv, tbl[i].x_ill});
      end
    end

    // Backpressure: pending R-only bundle, consumer stalls 10 cycles, then releases
    cycle(1, ADD, 0, 1, rdy);
    cycle(1, ADD, 0, 1, rdy);
    for (int i = 0; i < 10; i++) begin
      cycle(1, LD6, 0, 0, rdy);
      check("bp_in_ready", rdy, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_r_instr", bus.out_r_instr, ADD);
      check("bp_s_instr", bus.out_s_instr, 0);
      check("bp_vld", {bus.out_r_vld, bus.out_s_vld}, 2'b10);
    end
    cycle(1, LD6, 0, 1, rdy);
    check("bp_release_in_ready", rdy, 1);
    check("bp_release_r", bus.out_r_instr, ADD);
    check("bp_release_s", bus.out_s_instr, LD6);
    check("bp_release_vld", {bus.out_valid, bus.out_r_vld, bus.out_s_vld}, 3'b111);
    cycle(0, 0, 0, 1, rdy);
    check("bp_drained", bus.out_valid, 0);

    // Reset mid-hold with a bundle pending
    cycle(1, ADD, 0, 1, rdy);
    cycle(1, ADD, 0, 1, rdy);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < TO + 4; i++) begin
      cycle(0, 0, 0, 1, rdy);
      if (bus.out_valid) seen++;
    end
    check("post_reset_no_bundle", seen, 0);

    // Randomized traffic against the model
    idle_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          iv, fl, ordy;
      logic [31:0] ins;
      if (idle_left > 0) begin
        idle_left--;
        iv = 1'b0;
      end else begin
        iv = ($urandom_range(0, 99) < 60);
        if ($urandom_range(0, 99) < 3) idle_left = $urandom_range(5, 12);
      end
      ins  = rand_instr();
      fl   = ($urandom_range(0, 99) < 4);
      ordy = ($urandom_range(0, 99) < 70);
      cycle(iv, ins, fl, ordy, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
